// File: rtl/alsu_pipe_if.sv
// alsu_pipe_if
// Bundle of the ALSU operand/control inputs and its result outputs.
// The master side (driver) produces the input bundle and consumes the
// result; the slave side (the ALSU) does the opposite.
//   valid_in                 input bundle valid this cycle
//   A, B                     operands, WIDTH bits
//   cin, serial_in, direction carry-in, shift input bit, 1 = left / 0 = right
//   red_op_A, red_op_B       reduction selects
//   bypass_A, bypass_B       bypass selects
//   opcode                   0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE
//   valid_out                result register updated this cycle
//   out                      result register, 2*WIDTH bits
//   leds                     invalid indicator
//   invalid_cnt              saturating count of invalid results
interface alsu_pipe_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16
);
    localparam int OUT_W = 2 * WIDTH;

    logic             valid_in;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             serial_in;
    logic             direction;
    logic             red_op_A;
    logic             red_op_B;
    logic             bypass_A;
    logic             bypass_B;
    logic [2:0]       opcode;
    logic             valid_out;
    logic [OUT_W-1:0] out;
    logic [LED_W-1:0] leds;
    logic [7:0]       invalid_cnt;

    modport master (
        output valid_in, A, B, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, opcode,
        input  valid_out, out, leds, invalid_cnt
    );

    modport slave (
        input  valid_in, A, B, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, opcode,
        output valid_out, out, leds, invalid_cnt
    );
endinterface

// File: rtl/alsu_pipe.sv
// alsu_pipe
// Two-stage pipelined arithmetic/logic/shift unit with a valid handshake.
// Stage 1 registers the input bundle when valid_in is high; stage 2
// computes the result from the stage-1 registers into the out register.
// Invalid operations clear the result, light all leds and start a blink
// sequence, and bump a saturating invalid-result counter.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   alsu_pipe_if slave modport (inputs bundle, result outputs)
module alsu_pipe #(
    parameter int WIDTH        = 3,
    parameter int LED_W        = 16,
    parameter int SIGNED       = 1,
    parameter int FULL_ADDER   = 1,
    parameter int BLINK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    alsu_pipe_if.slave bus
);
    localparam int OUT_W = 2 * WIDTH;
    localparam int CNT_W = (BLINK_CYCLES < 2) ? 1 : $clog2(BLINK_CYCLES + 1);

    typedef enum logic {
        LED_OFF,
        LED_BLINK
    } led_state_t;

    // Stage-1 registers
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d, ser_q, ser_d, dir_q, dir_d;
    logic             red_a_q, red_a_d, red_b_q, red_b_d;
    logic             byp_a_q, byp_a_d, byp_b_q, byp_b_d;
    logic [2:0]       opcode_q, opcode_d;

    // Stage-2 / status registers
    logic             valid_out_q, valid_out_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [7:0]       invalid_cnt_q, invalid_cnt_d;
    led_state_t       state_q, state_d;

    logic [OUT_W-1:0] ext_a, ext_b, result;
    logic             is_invalid, hit_invalid;
    logic [CNT_W:0]   blink_inc;

    function automatic logic [OUT_W-1:0] ext(input logic [WIDTH-1:0] x);
        if (SIGNED != 0) return {{WIDTH{x[WIDTH-1]}}, x};
        else             return {{WIDTH{1'b0}}, x};
    endfunction

    // Stage 1 only loads on valid_in so idle cycles leave the bundle untouched.
    always_comb begin
        v1_d     = bus.valid_in;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        ser_d    = ser_q;
        dir_d    = dir_q;
        red_a_d  = red_a_q;
        red_b_d  = red_b_q;
        byp_a_d  = byp_a_q;
        byp_b_d  = byp_b_q;
        opcode_d = opcode_q;
        if (bus.valid_in) begin
            a_d      = bus.A;
            b_d      = bus.B;
            cin_d    = bus.cin;
            ser_d    = bus.serial_in;
            dir_d    = bus.direction;
            red_a_d  = bus.red_op_A;
            red_b_d  = bus.red_op_B;
            byp_a_d  = bus.bypass_A;
            byp_b_d  = bus.bypass_B;
            opcode_d = bus.opcode;
        end
    end

    // Result selection. Bypasses outrank the invalid check, so a bypassed
    // bundle with a bad opcode is a normal result. Reductions are only legal
    // with OR/XOR (opcode[2:1] == 0).
    always_comb begin
        ext_a       = ext(a_q);
        ext_b       = ext(b_q);
        is_invalid  = (opcode_q[2:1] == 2'b11) ||
                      ((red_a_q || red_b_q) && (opcode_q[2:1] != 2'b00));
        hit_invalid = !byp_a_q && !byp_b_q && is_invalid;
        result      = '0;
        if (byp_a_q) begin
            result = ext_a;
        end else if (byp_b_q) begin
            result = ext_b;
        end else if (is_invalid) begin
            result = '0;
        end else begin
            case (opcode_q)
                3'd0: begin
                    if (red_a_q)      result = {{(OUT_W-1){1'b0}}, |a_q};
                    else if (red_b_q) result = {{(OUT_W-1){1'b0}}, |b_q};
                    else              result = ext_a | ext_b;
                end
                3'd1: begin
                    if (red_a_q)      result = {{(OUT_W-1){1'b0}}, ^a_q};
                    else if (red_b_q) result = {{(OUT_W-1){1'b0}}, ^b_q};
                    else              result = ext_a ^ ext_b;
                end
                3'd2: result = ext_a + ext_b +
                               {{(OUT_W-1){1'b0}}, (FULL_ADDER != 0) ? cin_q : 1'b0};
                3'd3: result = ext_a * ext_b;
                // Shift and rotate chain on the current result register.
                3'd4: result = dir_q ? {out_q[OUT_W-2:0], ser_q}
                                     : {ser_q, out_q[OUT_W-1:1]};
                3'd5: result = dir_q ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                     : {out_q[0], out_q[OUT_W-1:1]};
                default: result = '0;
            endcase
        end
    end

    // Output register plus the led blink FSM. While blinking, the counter
    // runs every cycle (idle ones too) and flips leds each BLINK_CYCLES.
    // An accepted result overrides that: invalid restarts the blink with all
    // leds lit, anything else turns the leds off and leaves the blink state.
    always_comb begin
        valid_out_d   = v1_q;
        out_d         = out_q;
        leds_d        = leds_q;
        blink_cnt_d   = blink_cnt_q;
        invalid_cnt_d = invalid_cnt_q;
        state_d       = state_q;
        blink_inc     = {1'b0, blink_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        if (state_q == LED_BLINK) begin
            if (blink_inc == (CNT_W+1)'(BLINK_CYCLES)) begin
                leds_d      = ~leds_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_inc[CNT_W-1:0];
            end
        end
        if (v1_q) begin
            out_d       = result;
            blink_cnt_d = '0;
            if (hit_invalid) begin
                leds_d  = '1;
                state_d = LED_BLINK;
                if (invalid_cnt_q != 8'hFF) invalid_cnt_d = invalid_cnt_q + 8'd1;
            end else begin
                leds_d  = '0;
                state_d = LED_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
            ser_q         <= 1'b0;
            dir_q         <= 1'b0;
            red_a_q       <= 1'b0;
            red_b_q       <= 1'b0;
            byp_a_q       <= 1'b0;
            byp_b_q       <= 1'b0;
            opcode_q      <= '0;
            valid_out_q   <= 1'b0;
            out_q         <= '0;
            leds_q        <= '0;
            blink_cnt_q   <= '0;
            invalid_cnt_q <= '0;
            state_q       <= LED_OFF;
        end else begin
            v1_q          <= v1_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cin_q         <= cin_d;
            ser_q         <= ser_d;
            dir_q         <= dir_d;
            red_a_q       <= red_a_d;
            red_b_q       <= red_b_d;
            byp_a_q       <= byp_a_d;
            byp_b_q       <= byp_b_d;
            opcode_q      <= opcode_d;
            valid_out_q   <= valid_out_d;
            out_q         <= out_d;
            leds_q        <= leds_d;
            blink_cnt_q   <= blink_cnt_d;
            invalid_cnt_q <= invalid_cnt_d;
            state_q       <= state_d;
        end
    end

    assign bus.valid_out   = valid_out_q;
    assign bus.out         = out_q;
    assign bus.leds        = leds_q;
    assign bus.invalid_cnt = invalid_cnt_q;
endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe
// Directed bench for alsu_pipe. u_dut0: WIDTH=3, SIGNED=1, FULL_ADDER=1,
// BLINK_CYCLES=2. u_dut1: same but FULL_ADDER=0, BLINK_CYCLES=1.
// Each issued bundle pushes its hand-computed result onto a per-DUT queue;
// monitors pop and compare whenever valid_out is seen.
module tb_alsu_pipe;
    logic clk;
    logic rst;

    alsu_pipe_if #(.WIDTH(3), .LED_W(16)) if0 ();
    alsu_pipe_if #(.WIDTH(3), .LED_W(16)) if1 ();

    alsu_pipe #(.WIDTH(3), .LED_W(16), .SIGNED(1), .FULL_ADDER(1), .BLINK_CYCLES(2))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    alsu_pipe #(.WIDTH(3), .LED_W(16), .SIGNED(1), .FULL_ADDER(0), .BLINK_CYCLES(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        logic [5:0]  out;
        logic [15:0] leds;
        logic [7:0]  cnt;
        string       name;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   tests  = 0;
    int   failed = 0;
    int   exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: bumps the counters and reports mismatches.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one bundle on DUT sel for one cycle and queue its expected result.
    task automatic apply_stimulus(input bit sel, input logic [2:0] op,
                                  input logic [2:0] a, input logic [2:0] b,
                                  input logic ci, input logic ser, input logic dir,
                                  input logic ra, input logic rb,
                                  input logic ba, input logic bb,
                                  input logic [5:0] e_out, input logic [15:0] e_leds,
                                  input logic [7:0] e_cnt, input string name);
        exp_t e;
        e.out = e_out; e.leds = e_leds; e.cnt = e_cnt; e.name = name;
        if (!sel) begin
            if0.valid_in = 1'b1; if0.opcode = op; if0.A = a; if0.B = b;
            if0.cin = ci; if0.serial_in = ser; if0.direction = dir;
            if0.red_op_A = ra; if0.red_op_B = rb; if0.bypass_A = ba; if0.bypass_B = bb;
            sb0.push_back(e);
        end else begin
            if1.valid_in = 1'b1; if1.opcode = op; if1.A = a; if1.B = b;
            if1.cin = ci; if1.serial_in = ser; if1.direction = dir;
            if1.red_op_A = ra; if1.red_op_B = rb; if1.bypass_A = ba; if1.bypass_B = bb;
            sb1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        if0.valid_in = 1'b0;
        if1.valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitors: every valid_out must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if0.valid_out === 1'b1) begin
            tests++;
            if (sb0.size() == 0) begin
                failed++;
                $display("[TB] FAIL dut0 valid_out: got 1 with no pending result, expected 0");
            end else begin
                e0 = sb0.pop_front();
                check_output({"dut0 ", e0.name, " out"},  32'(if0.out),         32'(e0.out));
                check_output({"dut0 ", e0.name, " leds"}, 32'(if0.leds),        32'(e0.leds));
                check_output({"dut0 ", e0.name, " cnt"},  32'(if0.invalid_cnt), 32'(e0.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (if1.valid_out === 1'b1) begin
            tests++;
            if (sb1.size() == 0) begin
                failed++;
                $display("[TB] FAIL dut1 valid_out: got 1 with no pending result, expected 0");
            end else begin
                e1 = sb1.pop_front();
                check_output({"dut1 ", e1.name, " out"},  32'(if1.out),         32'(e1.out));
                check_output({"dut1 ", e1.name, " leds"}, 32'(if1.leds),        32'(e1.leds));
                check_output({"dut1 ", e1.name, " cnt"},  32'(if1.invalid_cnt), 32'(e1.cnt));
            end
        end
    end

    initial begin
        logic [15:0] blink0 [5];
        logic [15:0] blink1 [3];
        blink0 = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        blink1 = '{16'hFFFF, 16'h0000, 16'hFFFF};

        rst = 1'b0;
        {if0.valid_in, if0.A, if0.B, if0.cin, if0.serial_in, if0.direction,
         if0.red_op_A, if0.red_op_B, if0.bypass_A, if0.bypass_B, if0.opcode} = '0;
        {if1.valid_in, if1.A, if1.B, if1.cin, if1.serial_in, if1.direction,
         if1.red_op_A, if1.red_op_B, if1.bypass_A, if1.bypass_B, if1.opcode} = '0;

        @(negedge clk);
        check_output("reset out",       32'(if0.out),         32'h0);
        check_output("reset leds",      32'(if0.leds),        32'h0);
        check_output("reset valid_out", 32'(if0.valid_out),   32'h0);
        check_output("reset cnt",       32'(if0.invalid_cnt), 32'h0);
        rst = 1'b1;

        // Back-to-back bundles, ending in a SHIFT/ROTATE chain.
        //              sel op    A       B       ci ser dir ra rb ba bb  out        leds     cnt
        apply_stimulus(0, 3'd3, 3'b101, 3'b010, 0, 0, 0, 0, 0, 0, 0, 6'b111010, 16'h0, 8'd0, "mult -3*2");
        apply_stimulus(0, 3'd2, 3'b101, 3'b010, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 16'h0, 8'd0, "add -3+2+1");
        apply_stimulus(0, 3'd6, 3'b101, 3'b001, 0, 0, 0, 0, 0, 1, 1, 6'b111101, 16'h0, 8'd0, "both bypass");
        apply_stimulus(0, 3'd7, 3'b000, 3'b110, 0, 0, 0, 0, 0, 0, 1, 6'b111110, 16'h0, 8'd0, "bypass_B op7");
        apply_stimulus(0, 3'd0, 3'b101, 3'b010, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 16'h0, 8'd0, "or");
        apply_stimulus(0, 3'd1, 3'b101, 3'b011, 0, 0, 0, 0, 0, 0, 0, 6'b111110, 16'h0, 8'd0, "xor");
        apply_stimulus(0, 3'd0, 3'b000, 3'b111, 0, 0, 0, 1, 1, 0, 0, 6'b000000, 16'h0, 8'd0, "or red A wins");
        apply_stimulus(0, 3'd1, 3'b000, 3'b100, 0, 0, 0, 0, 1, 0, 0, 6'b000001, 16'h0, 8'd0, "xor red B");
        apply_stimulus(0, 3'd4, 3'b000, 3'b000, 0, 1, 1, 0, 0, 0, 0, 6'b000011, 16'h0, 8'd0, "shift left");
        apply_stimulus(0, 3'd5, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 6'b100001, 16'h0, 8'd0, "rotate right");
        apply_stimulus(0, 3'd4, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 6'b010000, 16'h0, 8'd0, "shift right");
        apply_stimulus(0, 3'd5, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0, 6'b100000, 16'h0, 8'd0, "rotate left");
        idle(2);
        check_output("idle out hold",  32'(if0.out),       32'h20);
        check_output("idle valid_out", 32'(if0.valid_out), 32'h0);

        // Invalid result then idle: blink every 2 cycles.
        apply_stimulus(0, 3'd6, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 16'hFFFF, 8'd1, "invalid op6");
        if0.valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output($sformatf("blink2 leds k=%0d", k), 32'(if0.leds), 32'(blink0[k]));
        end
        apply_stimulus(0, 3'd0, 3'b001, 3'b010, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 16'h0, 8'd1, "or leaves blink");
        apply_stimulus(0, 3'd2, 3'b111, 3'b001, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 16'hFFFF, 8'd2, "red_A with add");

        // Saturation of the invalid counter.
        exp_cnt = 2;
        for (int i = 0; i < 300; i++) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            apply_stimulus(0, 3'd7, 3'b010, 3'b011, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 16'hFFFF,
                           8'(exp_cnt), "invalid burst");
        end
        apply_stimulus(0, 3'd6, 3'b011, 3'b000, 0, 0, 0, 0, 0, 1, 0, 6'b000011, 16'h0, 8'd255, "bypass_A op6");
        idle(3);

        // Reset one cycle after a valid_in, with valid_in still high.
        if0.valid_in = 1'b1; if0.opcode = 3'd3; if0.A = 3'b011; if0.B = 3'b011;
        if0.bypass_A = 1'b0; if0.bypass_B = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("async reset out",       32'(if0.out),         32'h0);
        check_output("async reset cnt",       32'(if0.invalid_cnt), 32'h0);
        check_output("async reset leds",      32'(if0.leds),        32'h0);
        check_output("async reset valid_out", 32'(if0.valid_out),   32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        if0.valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output($sformatf("post reset valid_out k=%0d", k), 32'(if0.valid_out), 32'h0);
        end

        // Half adder variant and single-cycle blink on u_dut1.
        apply_stimulus(1, 3'd2, 3'b101, 3'b010, 1, 0, 0, 0, 0, 0, 0, 6'b111111, 16'h0, 8'd0, "add no cin");
        apply_stimulus(1, 3'd7, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 16'hFFFF, 8'd1, "invalid op7");
        if1.valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("blink1 leds k=%0d", k), 32'(if1.leds), 32'(blink1[k]));
        end

        // Bounded drain, then every queued result must have been seen.
        idle(1);
        for (int t = 0; t < 20 && (sb0.size() + sb1.size()) != 0; t++) @(negedge clk);
        check_output("scoreboard drained", 32'(sb0.size() + sb1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
